// File: rtl/sub64_pkg.sv
// Shared widths, per-stage payload and lookahead helper for the 64-bit pipelined subtractor.
package sub64_pkg;

  localparam int unsigned DW = 64;
  localparam int unsigned SW = 16;
  localparam int unsigned NS = DW / SW;
  localparam int unsigned GW = 4;

  // Operands ride along in full; each stage fills in its own diff slice.
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] d;
    logic          brw;
  } stage_t;

  // Group borrow-generate: G = g3 | p3(g2 | p2(g1 | p1 g0)).
  function automatic logic grp_generate(input logic [GW-1:0] g, input logic [GW-1:0] p);
    logic r;
    r = g[0];
    for (int i = 1; i < GW; i++) begin
      r = g[i] | (p[i] & r);
    end
    return r;
  endfunction

endpackage

// File: rtl/sub16_bla.sv
// One combinational 16-bit borrow-lookahead subtract slice built from 4-bit groups.
module sub16_bla
  import sub64_pkg::*;
(
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          bin_i,
  output logic [SW-1:0] d_o,
  output logic          bout_o
);

  localparam int unsigned NG = SW / GW;

  logic [SW-1:0] g, p, brw;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;

  assign g = ~a_i & b_i;
  assign p = ~(a_i ^ b_i);

  // Group borrows come from lookahead; bits inside a group ripple from the group borrow.
  always_comb begin
    gg    = '0;
    gp    = '0;
    gc    = '0;
    brw   = '0;
    gc[0] = bin_i;
    for (int j = 0; j < NG; j++) begin
      gg[j]      = grp_generate(g[GW*j +: GW], p[GW*j +: GW]);
      gp[j]      = &p[GW*j +: GW];
      gc[j+1]    = gg[j] | (gp[j] & gc[j]);
      brw[GW*j]  = gc[j];
      for (int i = 1; i < GW; i++) begin
        brw[GW*j+i] = g[GW*j+i-1] | (p[GW*j+i-1] & brw[GW*j+i-1]);
      end
    end
  end

  assign d_o    = a_i ^ b_i ^ brw;
  assign bout_o = gc[NG];

endmodule

// File: rtl/sub64_pipe.sv
// Four-stage valid/ready pipelined 64-bit subtractor (diff = dina - dinb - bin).
// Define SUB64_FLAGS_EN to add the registered zero and signed-overflow flags.
module sub64_pipe
  import sub64_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dina,
  input  logic [DW-1:0] dinb,
  input  logic          bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] diff,
  output logic          bout
`ifdef SUB64_FLAGS_EN
  ,
  output logic          zero,
  output logic          ovf
`endif
);

  stage_t [NS-1:0] st_q, st_d, src;
  logic   [NS-1:0] v_q, v_d, vin, ld;
  logic   [NS:0]   en;

  logic [NS-1:0][SW-1:0] sl_a, sl_b, sl_d;
  logic [NS-1:0]         sl_bin, sl_bout;

  // Stage k may advance when it is empty or everything after it advances.
  always_comb begin
    en     = '0;
    en[NS] = out_ready;
    for (int k = NS - 1; k >= 0; k--) begin
      en[k] = ~v_q[k] | en[k+1];
    end
  end

  assign vin      = {v_q[NS-2:0], in_valid};
  assign v_d      = (en[NS-1:0] & vin) | (~en[NS-1:0] & v_q);
  assign ld       = en[NS-1:0] & vin;
  assign in_ready = en[0];

  always_comb begin
    src        = '0;
    src[0].a   = dina;
    src[0].b   = dinb;
    src[0].brw = bin;
    for (int k = 1; k < NS; k++) begin
      src[k] = st_q[k-1];
    end
  end

  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_bin = '0;
    for (int k = 0; k < NS; k++) begin
      sl_a[k]   = src[k].a[SW*k +: SW];
      sl_b[k]   = src[k].b[SW*k +: SW];
      sl_bin[k] = src[k].brw;
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_slice
    sub16_bla u_slice (
      .a_i    (sl_a[k]),
      .b_i    (sl_b[k]),
      .bin_i  (sl_bin[k]),
      .d_o    (sl_d[k]),
      .bout_o (sl_bout[k])
    );
  end

  always_comb begin
    st_d = src;
    for (int k = 0; k < NS; k++) begin
      st_d[k].d[SW*k +: SW] = sl_d[k];
      st_d[k].brw           = sl_bout[k];
    end
  end

  // Payload only loads with valid data so a stalled or drained output holds steady.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      st_q <= '0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < NS; k++) begin
        if (ld[k]) begin
          st_q[k] <= st_d[k];
        end
      end
    end
  end

  assign out_valid = v_q[NS-1];
  assign diff      = st_q[NS-1].d;
  assign bout      = st_q[NS-1].brw;

`ifdef SUB64_FLAGS_EN
  logic zero_q, zero_d, ovf_q, ovf_d;

  always_comb begin
    zero_d = (st_d[NS-1].d == '0);
    ovf_d  = (src[NS-1].a[DW-1] != src[NS-1].b[DW-1]) &&
             (st_d[NS-1].d[DW-1] != src[NS-1].a[DW-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (ld[NS-1]) begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

  // Consumed operand slices are dead after their stage; synthesis prunes them.
  logic unused_st;
  assign unused_st = ^st_q;

endmodule

// File: tb/tb_sub64_pipe.sv
// Self-checking bench for sub64_pipe: directed vectors, stall, mid-flight reset, random stream.
module tb_sub64_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, bin, out_valid, out_ready, bout;
  logic [63:0] dina, dinb, diff;
`ifdef SUB64_FLAGS_EN
  logic        zero, ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_in    = 0;

  always #5 clk = ~clk;

  sub64_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dina      (dina),
    .dinb      (dinb),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB64_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] d;
    logic        b;
    logic        z;
    logic        o;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bi;
    logic [63:0] d;
    logic        bo;
    logic        z;
    logic        o;
  } vec_t;

  exp_t exp_q[$];
  exp_t e_pop;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_diff;
  logic        prev_bout;

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic bi);
    exp_t m;
    logic [64:0] r;
    r   = {1'b0, a} - {1'b0, b} - {64'd0, bi};
    m.d = r[63:0];
    m.b = r[64];
    m.z = (r[63:0] == 64'd0);
    m.o = (a[63] != b[63]) && (r[63] != a[63]);
    return m;
  endfunction

  // Scoreboard: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_diff", diff, prev_diff);
        check_eq("hold_bout", {63'd0, bout}, {63'd0, prev_bout});
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e_pop = exp_q.pop_front();
          check_eq("sb_diff", diff, e_pop.d);
          check_eq("sb_bout", {63'd0, bout}, {63'd0, e_pop.b});
`ifdef SUB64_FLAGS_EN
          check_eq("sb_zero", {63'd0, zero}, {63'd0, e_pop.z});
          check_eq("sb_ovf", {63'd0, ovf}, {63'd0, e_pop.o});
`endif
        end
      end
      if (in_valid && in_ready) begin
        n_in++;
        exp_q.push_back(model(dina, dinb, bin));
      end
      prev_stall = out_valid && !out_ready;
      prev_diff  = diff;
      prev_bout  = bout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one op into an empty pipe and checks latency and result against hand values.
  task automatic send_and_wait(input vec_t v, input string tag);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dina      = v.a;
    dinb      = v.b;
    bin       = v.bi;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check_eq({tag, "_latency"}, 64'(n), 64'd4);
    check_eq({tag, "_diff"}, diff, v.d);
    check_eq({tag, "_bout"}, {63'd0, bout}, {63'd0, v.bo});
`ifdef SUB64_FLAGS_EN
    check_eq({tag, "_zero"}, {63'd0, zero}, {63'd0, v.z});
    check_eq({tag, "_ovf"}, {63'd0, ovf}, {63'd0, v.o});
`endif
    tick();
  endtask

  vec_t vecs [9];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, base_out, first_block, saw, base_in;

    vecs[0] = '{64'd100, 64'd58, 1'b0, 64'd42, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{64'd5, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{64'h1_0000, 64'd1, 1'b0, 64'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{64'd7, 64'd7, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
                64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    dina      = '0;
    dinb      = '0;
    bin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_diff", diff, 64'd0);
    check_eq("rst_bout", {63'd0, bout}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef SUB64_FLAGS_EN
    check_eq("rst_zero", {63'd0, zero}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick();

    for (int i = 0; i < 9; i++) begin
      send_and_wait(vecs[i], $sformatf("vec%0d", i));
    end

    // Eight back-to-back ops with the output stalled in cycles 5..9.
    sent        = 0;
    base_out    = n_out;
    first_block = -1;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 5 && c <= 9);
      in_valid  = (sent < 8);
      dina      = 64'h1000 + 64'(sent) * 3;
      dinb      = 64'(sent);
      bin       = sent[0];
      @(negedge clk);
      if (in_valid && !in_ready && first_block < 0) first_block = c;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("stall_first_block", 64'(first_block), 64'd5);
    check_eq("stall_sent", 64'(sent), 64'd8);
    check_eq("stall_results", 64'(n_out - base_out), 64'd8);

    // Three ops in flight, then a one-cycle reset.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      dina     = 64'(c + 50);
      dinb     = 64'd3;
      bin      = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    tick();
    check_eq("rst_flush", 64'(saw), 64'd0);
    send_and_wait(vecs[0], "post_rst");

    // Random stream against the scoreboard.
    base_in = n_in;
    for (int c = 0; c < 60000; c++) begin
      if (n_in - base_in >= 10000 && exp_q.size() == 0) break;
      in_valid  = (n_in - base_in < 10000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      case ($urandom_range(7))
        0:       dina = 64'd0;
        1:       dina = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       dina = 64'h8000_0000_0000_0000;
        default: dina = {$urandom, $urandom};
      endcase
      case ($urandom_range(7))
        0:       dinb = 64'd0;
        1:       dinb = 64'hFFFF_FFFF_FFFF_FFFF;
        2:       dinb = dina;
        default: dinb = {$urandom, $urandom};
      endcase
      bin = 1'($urandom_range(1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("rand_sent", 64'(n_in - base_in), 64'd10000);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
